jk_excitation_driver: RTL

- Drives a WIDTH-bit bank of JK flip-flops (each with clk, rst, en, j, k, q) so the bank moves to a requested target value.
- Accepts a target over a valid/ready handshake. Computes per-bit J/K excitation from a shadow copy of the bank state and pulses enable for one cycle.
- Waits a settle interval, then reads back q and reports done plus a per-bit mismatch mask.
- It is the control side of the JK bank: it produces j/k/en and consumes q.

---
 rtl/jk_pkg.sv | 40 ++++
 rtl/jk_excite.sv | 32 +++
 rtl/jk_excitation_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared types and constants for the JK excitation driver:
//                FSM state encoding, 2-bit J/K excitation codes and the
//                settle-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Excitation code packed as {j, k}
    typedef logic [1:0] jk_code_t;

    localparam jk_code_t JK_HOLD   = 2'b00;
    localparam jk_code_t JK_RESET  = 2'b01;
    localparam jk_code_t JK_SET    = 2'b10;
    localparam jk_code_t JK_TOGGLE = 2'b11;   // reserved, never issued

    localparam int SETTLE_W = 4;

    // Excitation needed to move one flip-flop from cur to tgt
    function automatic jk_code_t jk_code(input logic cur, input logic tgt);
        if (cur == tgt) begin
            return JK_HOLD;
        end else if (tgt) begin
            return JK_SET;
        end else begin
            return JK_RESET;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excite
//  Description : Combinational per-bit mapping from current/target bank value
//                to J and K excitation. Never produces a toggle.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_code_t w_code;
        jk_code_t w_safe;

        assign w_code = jk_code(cur[gi], tgt[gi]);
        // A toggle code would make the bank outcome depend on its prior state;
        // squash it to hold so the bank can never be toggled from here.
        assign w_safe = (w_code == JK_TOGGLE) ? JK_HOLD : w_code;
        assign j[gi]  = w_safe[1];
        assign k[gi]  = w_safe[0];
    end

endmodule
`default_nettype wire

// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excitation_driver
//  Description : Control side of a JK flip-flop bank. Accepts a target value,
//                issues one enable cycle with per-bit J/K excitation computed
//                from a shadow copy of the bank, waits SETTLE cycles, reads q
//                back and reports done with a per-bit mismatch mask.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1     // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             en,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [SETTLE_W-1:0] c_settle = SETTLE_W'(SETTLE);

    state_t              r_state;
    logic [SETTLE_W-1:0] r_cnt;
    logic [WIDTH-1:0]    r_cur;
    logic [WIDTH-1:0]    r_tgt;
    logic [WIDTH-1:0]    r_j;
    logic [WIDTH-1:0]    r_k;
    logic [WIDTH-1:0]    r_mask;
    logic                r_en;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [WIDTH-1:0]    w_j;
    logic [WIDTH-1:0]    w_k;
    logic [WIDTH-1:0]    w_mask;

    // Excitation is computed from the incoming request so it can be
    // registered on the accept edge and appear with en in the next cycle.
    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .cur (r_cur),
        .tgt (tgt_data),
        .j   (w_j),
        .k   (w_k)
    );

    assign w_mask = q_fb ^ r_tgt;

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            r_tgt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_mask  <= '0;
            r_en    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tgt_valid && r_ready) begin
                        r_tgt   <= tgt_data;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= DRIVE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                DRIVE: begin
                    r_en    <= 1'b0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_cnt   <= c_settle;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt <= SETTLE_W'(1)) begin
                        // Shadow follows what the bank really did, so a stuck
                        // bit is excited correctly on the next request.
                        r_mask  <= w_mask;
                        r_err   <= |w_mask;
                        r_cur   <= q_fb;
                        r_done  <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - SETTLE_W'(1);
                    end
                end
                RESP: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tgt_ready = r_ready;
    assign j         = r_j;
    assign k         = r_k;
    assign en        = r_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_mask  = r_mask;

endmodule
`default_nettype wire
